// File: rtl/fuyang_cordic_pkg.sv
// Shared constants, ATAN table and FSM states for the CORDIC phase extractor.
package fuyang_cordic_pkg;

   localparam int ITER_DEFAULT      = 16;
   localparam int NUM_BEAMS_DEFAULT = 70;
   localparam int INT_W             = 19;  // internal x/y width, headroom for gain and pre-rotation
   localparam int PHASE_W           = 16;  // 65536 LSB = one full turn
   localparam int MAX_ITER          = 16;
   localparam int CNT_W             = 5;   // must hold ITER itself (finalize step)

   // round(atan(2^-i) * 65536 / (2*pi))
   localparam logic [PHASE_W-1:0] ATAN_TABLE [MAX_ITER] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297,
      16'd651,  16'd326,  16'd163,  16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,
      16'd3,    16'd1,    16'd1,    16'd0
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/fuyang_atan_rom.sv
// Combinational lookup of the CORDIC elementary angle for an iteration index.
module fuyang_atan_rom
   import fuyang_cordic_pkg::*;
(
   input  logic [CNT_W-1:0]   idx,
   output logic [PHASE_W-1:0] atan
);

   // Indices past the table (the finalize step) read as zero
   always_comb begin
      atan = '0;
      if (idx < CNT_W'(MAX_ITER)) begin
         atan = ATAN_TABLE[idx[3:0]];
      end
   end

endmodule

// File: rtl/fuyang_cordic_phase_extract.sv
// Iterative CORDIC vectoring: converts a Q1.15 complex sample into phase,
// gain-scaled magnitude and an elevation beam index.
module fuyang_cordic_phase_extract
   import fuyang_cordic_pkg::*;
#(
   parameter int ITER      = ITER_DEFAULT,
   parameter int NUM_BEAMS = NUM_BEAMS_DEFAULT
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_real,
   input  logic [15:0]   in_image,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_phase,
   output logic [16:0]   out_mag,
   output logic [6:0]    out_c
);

   localparam int PROD_W = PHASE_W + 7;

   state_t                    state_reg, state_next;
   logic signed [INT_W-1:0]   x_reg, y_reg;
   logic [PHASE_W-1:0]        z_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [6:0]                c_reg;
   logic                      zero_reg;

   logic signed [INT_W-1:0]   re_ext, im_ext;
   logic signed [INT_W-1:0]   pre_x, pre_y;
   logic [PHASE_W-1:0]        pre_z;
   logic signed [INT_W-1:0]   x_shift, y_shift;
   logic signed [INT_W-1:0]   x_rot, y_rot;
   logic [PHASE_W-1:0]        z_rot;
   logic [PHASE_W-1:0]        atan_val;
   logic [PROD_W-1:0]         beam_prod;
   logic [6:0]                beam_c;
   logic                      last_step;
   logic                      unused_bits;

   fuyang_atan_rom u_atan_rom (
      .idx  (cnt_reg),
      .atan (atan_val)
   );

   // The extra step at cnt == ITER performs no rotation; it only registers the beam index
   assign last_step = (cnt_reg == CNT_W'(ITER));

   // Pre-rotation into the right half-plane so the vectoring loop converges
   always_comb begin
      re_ext = {{(INT_W-16){in_real[15]}}, in_real};
      im_ext = {{(INT_W-16){in_image[15]}}, in_image};
      pre_x  = re_ext;
      pre_y  = im_ext;
      pre_z  = '0;
      if (in_real[15]) begin
         pre_x = -re_ext;
         pre_y = -im_ext;
         pre_z = 16'h8000;
      end
   end

   // One micro-rotation driving y toward zero; z accumulates the rotated angle
   always_comb begin
      x_shift = x_reg >>> cnt_reg;
      y_shift = y_reg >>> cnt_reg;
      if (!y_reg[INT_W-1]) begin
         x_rot = x_reg + y_shift;
         y_rot = y_reg - x_shift;
         z_rot = z_reg + atan_val;
      end else begin
         x_rot = x_reg - y_shift;
         y_rot = y_reg + x_shift;
         z_rot = z_reg - atan_val;
      end
      // A zero vector has no angle; keep z at 0 instead of summing the whole table
      if (zero_reg) begin
         z_rot = z_reg;
      end
   end

   // Beam quantizer: floor(phase * NUM_BEAMS / 65536) + 1
   always_comb begin
      beam_prod = {7'd0, z_reg} * PROD_W'(NUM_BEAMS);
      beam_c    = beam_prod[PROD_W-1:PHASE_W] + 7'd1;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: accept, iterate, hold result until taken
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (in_valid)  state_next = ST_ROTATE;
         ST_ROTATE: if (last_step) state_next = ST_DONE;
         ST_DONE:   if (out_ready) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Datapath: latch on accept, rotate per cycle, register beam on entry to DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg    <= '0;
         y_reg    <= '0;
         z_reg    <= '0;
         cnt_reg  <= '0;
         c_reg    <= 7'd1;
         zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  x_reg    <= pre_x;
                  y_reg    <= pre_y;
                  z_reg    <= pre_z;
                  cnt_reg  <= '0;
                  zero_reg <= (in_real == 16'd0) && (in_image == 16'd0);
               end
            end
            ST_ROTATE: begin
               if (last_step) begin
                  c_reg <= beam_c;
               end else begin
                  x_reg   <= x_rot;
                  y_reg   <= y_rot;
                  z_reg   <= z_rot;
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign out_phase = z_reg;
   assign out_mag   = x_reg[16:0];
   assign out_c     = c_reg;

   // x is non-negative and below 2^17 at the output; its top bits and the
   // fractional product bits are intentionally dropped
   assign unused_bits = ^{x_reg[INT_W-1:17], beam_prod[PHASE_W-1:0]};

endmodule
